// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data memory access controller with alignment, lane steering,
// load extension, pipeline stall generation and a 16-cycle bus timeout.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        Reset,
    input  logic        mem_req_valid,
    input  logic        mem_is_store,
    input  logic [1:0]  mem_size,
    input  logic        load_signed,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic        stall,
    output logic        wb_bubble,
    output logic [31:0] load_data,
    output logic        load_data_valid,
    output logic        misalign_exc,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_addr, r_wdata, r_load_data, w_wdata_rep, w_ext;
    logic [3:0]  r_be, r_cnt, w_be;
    logic [1:0]  r_size;
    logic        r_store, r_signed, r_bus_err;
    logic        w_misalign, w_idle, w_busy, w_start, w_timeout;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_idle     = r_state == IDLE;
    assign w_busy     = r_state == BUSY;
    assign w_misalign = (mem_size == 2'b01 && mem_addr[0]) || (mem_size[1] && |mem_addr[1:0]);
    assign w_start    = w_idle && mem_req_valid && !w_misalign;
    assign w_timeout  = w_busy && !dmem_ack && &r_cnt;

    assign w_be = mem_size == 2'b00 ? 4'b0001 << mem_addr[1:0] :
                  mem_size == 2'b01 ? (mem_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wdata_rep = mem_size == 2'b00 ? {4{mem_wdata[7:0]}} :
                         mem_size == 2'b01 ? {2{mem_wdata[15:0]}} : mem_wdata;

    // Lane selection uses the latched address since mem_addr may change while stalled
    assign w_byte = dmem_rdata[8*r_addr[1:0] +: 8];
    assign w_half = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    assign w_ext  = r_size == 2'b00 ? {{24{r_signed & w_byte[7]}}, w_byte} :
                    r_size == 2'b01 ? {{16{r_signed & w_half[15]}}, w_half} : dmem_rdata;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = w_idle ? (w_start ? BUSY : IDLE) :
                 w_busy ? ((dmem_ack || &r_cnt) ? DONE : BUSY) : IDLE;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_size      <= '0;
            r_store     <= 1'b0;
            r_signed    <= 1'b0;
            r_cnt       <= '0;
            r_load_data <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr   <= mem_addr;
                r_wdata  <= w_wdata_rep;
                r_be     <= w_be;
                r_size   <= mem_size;
                r_store  <= mem_is_store;
                r_signed <= load_signed;
            end
            r_cnt <= w_start ? 4'd0 : (w_busy && !dmem_ack) ? r_cnt + 4'd1 : r_cnt;
            if (w_busy && dmem_ack && !r_store) r_load_data <= w_ext;
            else if (w_timeout)                 r_load_data <= '0;
            r_bus_err <= w_timeout;
        end
    end

    always_comb begin
        stall           = !Reset && (w_start || w_busy);
        wb_bubble       = stall;
        misalign_exc    = !Reset && w_idle && mem_req_valid && w_misalign;
        dmem_req        = w_busy;
        dmem_we         = w_busy && r_store;
        dmem_be         = w_busy ? r_be : 4'b0000;
        dmem_addr       = {r_addr[31:2], 2'b00};
        dmem_wdata      = r_wdata;
        load_data       = r_load_data;
        load_data_valid = r_state == DONE && !r_store;
        bus_err         = r_bus_err;
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench; driver pushes expected requests/completions,
// a negedge monitor pops and compares whenever the DUT issues or completes an access.
module tb_mem_access_ctrl;
    logic        clk = 1'b0, Reset = 1'b1;
    logic        mem_req_valid = 1'b0, mem_is_store = 1'b0, load_signed = 1'b0, dmem_ack = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic [31:0] mem_addr = '0, mem_wdata = '0, dmem_rdata = '0;
    logic        dmem_req, dmem_we, stall, wb_bubble, load_data_valid, misalign_exc, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, load_data;
    logic [3:0]  dmem_be;

    int tests = 0, fails = 0;
    logic [31:0] model_ld = '0;

    typedef struct { logic [31:0] addr; logic [31:0] wdata; logic we; logic [3:0] be; } req_t;
    typedef struct { logic valid; logic [31:0] data; logic berr; } cpl_t;
    req_t req_q[$];
    cpl_t cpl_q[$];

    mem_access_ctrl dut (
        .clk(clk), .Reset(Reset), .mem_req_valid(mem_req_valid), .mem_is_store(mem_is_store),
        .mem_size(mem_size), .load_signed(load_signed), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .stall(stall),
        .wb_bubble(wb_bubble), .load_data(load_data), .load_data_valid(load_data_valid),
        .misalign_exc(misalign_exc), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic is_mis(input logic [1:0] sz, input logic [31:0] a);
        return sz == 2'd1 ? (a % 2 != 0) : sz >= 2'd2 ? (a % 4 != 0) : 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int off = int'(a % 4);
        return sz == 2'd0 ? 4'(1 << off) : sz == 2'd1 ? 4'(3 << off) : 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
        return sz == 2'd0 ? (w & 32'hFF) * 32'h01010101 :
               sz == 2'd1 ? (w & 32'hFFFF) * 32'h00010001 : w;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sg,
                                           input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v = rd >> (8 * (a % 4));
        if (sz == 2'd0) begin
            v = v & 32'hFF;
            if (sg && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = v & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else v = rd;
        return v;
    endfunction

    // ackc: BUSY cycle (1-based) on which ack arrives; 0 means never (timeout)
    task automatic access(input logic st, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input int ackc);
        req_t r;
        cpl_t c;
        int sc, nb;
        nb = ackc == 0 ? 16 : ackc;
        r.addr = a & 32'hFFFFFFFC;
        r.we = st;
        r.be = m_be(sz, a);
        r.wdata = m_wdata(sz, wd);
        req_q.push_back(r);
        if (ackc == 0) begin
            c.valid = !st; c.data = 32'h0; c.berr = 1'b1; model_ld = 32'h0;
        end else if (!st) begin
            c.valid = 1'b1; c.data = m_load(sz, sg, a, rd); c.berr = 1'b0; model_ld = c.data;
        end else begin
            c.valid = 1'b0; c.data = model_ld; c.berr = 1'b0;
        end
        cpl_q.push_back(c);
        step();
        mem_req_valid = 1'b1; mem_is_store = st; mem_size = sz; load_signed = sg;
        mem_addr = a; mem_wdata = wd; dmem_ack = 1'($urandom % 2); dmem_rdata = $urandom;
        #1;
        sc = int'(stall);
        chk("misalign_on_aligned", 32'(misalign_exc), 32'h0);
        for (int k = 1; k <= nb; k++) begin
            step();
            dmem_ack = (k == ackc);
            dmem_rdata = dmem_ack ? rd : $urandom;
            #1;
            sc += int'(stall);
        end
        step();
        dmem_ack = 1'b1;
        dmem_rdata = $urandom;
        #1;
        chk("stall_in_done", 32'(stall), 32'h0);
        chk("stall_cycles", 32'(sc), 32'(nb + 1));
        step();
        mem_req_valid = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic misaligned(input logic [1:0] sz, input logic [31:0] a);
        step();
        mem_req_valid = 1'b1; mem_is_store = 1'($urandom % 2); mem_size = sz; mem_addr = a;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("misalign_exc", 32'(misalign_exc), 32'h1);
            chk("misalign_stall", 32'(stall), 32'h0);
            chk("misalign_req", 32'(dmem_req), 32'h0);
            step();
        end
        mem_req_valid = 1'b0;
        #1;
        chk("misalign_clear", 32'(misalign_exc), 32'h0);
    endtask

    task automatic reset_mid_busy();
        req_t r;
        r.addr = 32'h4000; r.we = 1'b0; r.be = 4'hF; r.wdata = 32'h0;
        req_q.push_back(r);
        step();
        mem_req_valid = 1'b1; mem_is_store = 1'b0; mem_size = 2'd2; mem_addr = 32'h4000;
        step();
        step();
        #3;
        Reset = 1'b1;
        mem_req_valid = 1'b0;
        #1;
        chk("rst_dmem_req", 32'(dmem_req), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        model_ld = 32'h0;
        step();
        Reset = 1'b0;
        step();
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        for (int k = 0; k < 2; k++) begin
            step();
            dmem_ack = 1'b0;
            chk("late_ack_valid", 32'(load_data_valid), 32'h0);
            chk("late_ack_data", load_data, 32'h0);
        end
    endtask

    initial begin : monitor
        req_t cur;
        cpl_t c;
        logic p_req = 1'b0;
        cur = '{default: '0};
        forever begin
            @(negedge clk);
            if (!Reset) begin
                if (dmem_req && !p_req) begin
                    if (req_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_req: got addr %h expected no request", dmem_addr);
                    end else begin
                        cur = req_q.pop_front();
                        chk("req_addr", dmem_addr, cur.addr);
                        chk("req_we", 32'(dmem_we), 32'(cur.we));
                        chk("req_be", 32'(dmem_be), 32'(cur.be));
                        if (cur.we) chk("req_wdata", dmem_wdata, cur.wdata);
                    end
                end else if (dmem_req) begin
                    chk("hold_addr", dmem_addr, cur.addr);
                    chk("hold_be", 32'(dmem_be), 32'(cur.be));
                end
                if (load_data_valid || bus_err || (p_req && !dmem_req)) begin
                    if (cpl_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_cpl: got valid %b berr %b expected none",
                                 load_data_valid, bus_err);
                    end else begin
                        c = cpl_q.pop_front();
                        chk("cpl_valid", 32'(load_data_valid), 32'(c.valid));
                        chk("cpl_data", load_data, c.data);
                        chk("cpl_berr", 32'(bus_err), 32'(c.berr));
                        chk("cpl_req_low", 32'(dmem_req | dmem_we | |dmem_be), 32'h0);
                    end
                end
            end
            p_req = Reset ? 1'b0 : dmem_req;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [1:0]  sz;
        logic [31:0] a;
        int r, ackc;
        repeat (3) step();
        chk("reset_req", 32'({dmem_req, dmem_we, dmem_be, stall, wb_bubble}), 32'h0);
        chk("reset_out", 32'({load_data_valid, bus_err, misalign_exc}), 32'h0);
        chk("reset_data", load_data, 32'h0);
        Reset = 1'b0;
        access(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'hDEADBEEF, 3);
        access(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h80112233, 1);
        access(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h80112233, 2);
        access(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000ABCD, 32'h0, 2);
        misaligned(2'd2, 32'h2001);
        misaligned(2'd1, 32'h2003);
        access(1'b0, 2'd2, 1'b0, 32'h3000, 32'h0, 32'h55555555, 0);
        access(1'b0, 2'd1, 1'b1, 32'h3006, 32'h0, 32'h9ABC1234, 16);
        access(1'b1, 2'd0, 1'b0, 32'h3001, 32'h000000A5, 32'h0, 0);
        reset_mid_busy();
        for (int i = 0; i < 60; i++) begin
            sz = 2'($urandom % 4);
            a = $urandom;
            if ($urandom % 4 != 0) a = sz == 2'd0 ? a : sz == 2'd1 ? a & ~32'h1 : a & ~32'h3;
            r = int'($urandom % 10);
            ackc = r == 0 ? 0 : r == 1 ? 16 : 1 + int'($urandom % 4);
            if (is_mis(sz, a)) misaligned(sz, a);
            else access(1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom, $urandom, ackc);
        end
        repeat (3) step();
        chk("req_q_empty", 32'(req_q.size()), 32'h0);
        chk("cpl_q_empty", 32'(cpl_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-high reset.
- mem_req_valid  in  1  MEM-stage instruction is a load or store.
- mem_is_store  in  1  1 = store, 0 = load.
- mem_size  in  2  00 = byte, 01 = half, 10/11 = word.
- load_signed  in  1  sign-extend byte/half loads.
- mem_addr  in  32  byte address from ALU.
- mem_wdata  in  32  store data, right-aligned.
- dmem_ack  in  1  memory completes the access this cycle.
- dmem_rdata  in  32  read word, valid with dmem_ack.
- dmem_req  out  1  access request to data memory.
- dmem_we  out  1  write strobe.
- dmem_addr  out  32  word-aligned address, bits[1:0] = 00.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- stall  out  1  hold PC and all pipeline registers upstream of MEM/WB.
- wb_bubble  out  1  force RegWr = 0 into the MEM/WB register.
- load_data  out  32  aligned and extended load result.
- load_data_valid  out  1  load_data is valid this cycle.
- misalign_exc  out  1  misaligned access; the access is not issued.
- bus_err  out  1  timeout with no dmem_ack.

Function
REQ-002 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-003 In IDLE, when mem_req_valid = 1 and the access is aligned, the block SHALL latch address, store flag, size, sign, byte enables and store data, and SHALL move to BUSY.
REQ-004 Misalignment SHALL be defined as: half with addr[0] = 1, or word with addr[1:0] != 00.
- In IDLE, a misaligned access SHALL assert misalign_exc combinationally for that cycle.
- The FSM SHALL stay in IDLE.
- stall SHALL stay 0.
REQ-005 stall SHALL be combinational and equal 1 in IDLE with an aligned mem_req_valid, and 1 throughout BUSY; it SHALL be 0 otherwise.
REQ-006 wb_bubble SHALL equal stall.
REQ-007 In BUSY, dmem_req SHALL be 1 and dmem_addr, dmem_we, dmem_be and dmem_wdata SHALL be driven from the latched values, held stable until exit.
REQ-008 Outside BUSY, dmem_req, dmem_we and dmem_be SHALL be 0.
REQ-009 Byte enables SHALL be:
- byte: 4'b0001 shifted left by addr[1:0];
- half: addr[1] = 0 gives 0011, addr[1] = 1 gives 1100;
- word: 1111.
REQ-010 Store data SHALL be replicated across lanes: byte gives {4{wdata[7:0]}}, half gives {2{wdata[15:0]}}, word is passed through.
REQ-011 In BUSY with dmem_ack = 1 on a load, the block SHALL select the addressed byte or half from dmem_rdata, zero- or sign-extend it per load_signed, and register the result into load_data.
REQ-012 Completion SHALL move the FSM to DONE.
REQ-013 A 4-bit timeout counter SHALL:
- clear on entry to BUSY;
- increment on each BUSY cycle without ack.
REQ-014 When the counter equals 15 and dmem_ack = 0, the block SHALL:
- register bus_err = 1 for the DONE cycle;
- set load_data = 0;
- move to DONE.
REQ-015 If dmem_ack = 1 arrives in the same cycle the counter equals 15, the ack SHALL win and bus_err SHALL remain 0.
REQ-016 In DONE the block SHALL:
- hold stall = 0;
- drive load_data_valid = 1 for exactly one cycle, for loads only;
- ignore mem_req_valid, because the same instruction is still in MEM;
- return to IDLE unconditionally.
REQ-017 dmem_ack SHALL be ignored in IDLE and DONE.
REQ-018 Minimum access latency SHALL be IDLE, then BUSY with ack, then DONE: 2 stalled cycles plus 1 release cycle.
REQ-019 load_data SHALL hold its value until the next completion or reset.

Reset
REQ-020 Reset = 1 SHALL asynchronously force:
- the FSM to IDLE and the counter to 0;
- load_data to 0, and load_data_valid, bus_err, dmem_req, dmem_we and dmem_be to 0;
- stall to 0, and all latched fields to 0.
REQ-021 Reset asserted while in BUSY SHALL drop dmem_req immediately without waiting for the clock, and any later dmem_ack SHALL be ignored.

Verification
REQ-022 The bench SHALL cover:
- Word load: addr 0x1000, ack on the 3rd BUSY cycle, rdata 0xDEADBEEF. Expect stall high for 4 cycles, then load_data 0xDEADBEEF with load_data_valid for 1 cycle, and dmem_be 1111.
- Signed byte load: addr 0x1003, rdata 0x80112233. Expect dmem_be 1000 and load_data 0xFFFFFF80. Repeat unsigned: expect 0x00000080.
- Half store: addr 0x2002, wdata 0x0000ABCD. Expect dmem_we 1, dmem_be 1100, dmem_wdata 0xABCDABCD, dmem_addr 0x2000, and load_data_valid remains 0.
- Misaligned word: addr 0x2001. Expect misalign_exc 1 and dmem_req 0, with stall 0 throughout.
- Timeout: no ack. Expect bus_err 1 after the 16th BUSY cycle and load_data 0. Also ack exactly at count 15: expect bus_err 0 and data captured.
- Reset mid-BUSY: expect dmem_req and stall 0 before the next clk edge, then FSM in IDLE; a late ack SHALL cause no load_data_valid.
